// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } fetch_entry_s;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage_queue.sv
// Small synchronous FIFO (module fetch_queue): push/pop/flush with occupancy count.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, credit-limited imem requests, instruction queue, IF/ID register.
// Optional perf counters perf_fetched/perf_dropped are built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter int unsigned    XLEN     = fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              PCSrcE,
    input  logic [XLEN-1:0]   PCTargetE,
    fetch_stage_if.master     imem,
    output logic [XLEN-1:0]   PCF,
    output logic              ValidD,
    output logic [31:0]       InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);
    import fetch_stage_pkg::*;

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   iq_count, tag_count;
    logic [CW:0]     inflight;
    logic            req_fire, rsp_keep, rsp_drop, iq_pop, iq_empty, iq_full;
    logic            tag_full, tag_empty;
    logic [XLEN-1:0] tag_pc, pcf_d;
    fetch_entry_s    iq_wdata, iq_head;
    logic            unused_sig;

    // Queue slots are reserved at issue time, so a response never finds the queue full.
    assign inflight = {1'b0, outstanding_q} + {1'b0, drop_cnt_q} + {1'b0, iq_count};
    assign imem.imem_req_valid = rst && !StallF && !PCSrcE && (inflight < (CW+1)'(QDEPTH));
    assign imem.imem_req_addr  = PCF;
    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_drop = imem.imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_keep = imem.imem_rsp_valid && (drop_cnt_q == '0);
    assign iq_pop   = !FlushD && !StallD && !iq_empty;

    assign iq_wdata = '{instr: imem.imem_rsp_data, pc: tag_pc, pcplus4: tag_pc + XLEN'(4)};

    fetch_queue #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (imem.imem_rsp_valid),
        .flush (1'b0),
        .wdata (PCF),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fetch_queue #(.WIDTH($bits(fetch_entry_s)), .DEPTH(QDEPTH)) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (iq_pop),
        .flush (PCSrcE),
        .wdata (iq_wdata),
        .rdata (iq_head),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count)
    );

    assign unused_sig = ^{tag_full, tag_empty, tag_count, iq_full, PCTargetE[1:0]};

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_keep);
        drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
        pcf_d         = req_fire ? PCF + XLEN'(4) : PCF;
        if (PCSrcE) begin
            // Everything still in flight is wrong-path; a response kept this cycle is flushed.
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(rsp_keep) - CW'(rsp_drop);
            pcf_d         = {PCTargetE[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PCF           <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            PCF           <= pcf_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end else if (StallD) begin
            ValidD <= ValidD;
        end else if (!iq_empty) begin
            ValidD   <= 1'b1;
            InstrD   <= iq_head.instr;
            PCD      <= iq_head.pc;
            PCPlus4D <= iq_head.pcplus4;
        end else begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] flushed_n;

    assign flushed_n = PCSrcE ? 32'(iq_count) - 32'(iq_pop) + 32'(rsp_keep) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(iq_pop);
            perf_dropped <= perf_dropped + 32'(rsp_drop) + flushed_n;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order imem model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'h5A00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        ready = 1'b1;
    int          lat = 1;
    int          errors = 0;
    int          checks = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    logic [3:0]  pv;
    logic [31:0] pd [4];

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (imem),
        .PCF       (PCF),
        .ValidD    (ValidD),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    // Memory word at address a is a ^ TAG; response appears lat cycles after acceptance.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], imem.imem_req_valid && imem.imem_req_ready};
            pd[0] <= imem.imem_req_addr ^ TAG;
            for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
        end
    end

    assign imem.imem_req_ready = ready;
    assign imem.imem_rsp_valid = pv[lat-1];
    assign imem.imem_rsp_data  = pd[lat-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        step();
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0; ready = 1'b1; lat = l;
        step(); #1;
        chk("rst_pcf",    PCF, 32'h0);
        chk("rst_validd", 32'(ValidD), 32'd0);
        chk("rst_instrd", InstrD, NOP);
        chk("rst_pcd",    PCD, 32'h0);
        chk("rst_pcp4d",  PCPlus4D, 32'h0);
        chk("rst_reqv",   32'(imem.imem_req_valid), 32'd0);
        step();
        rst = 1'b1; #1;
    endtask

    initial begin
        // Streaming, then memory not ready for 5 cycles.
        do_reset(1);
        chk("a_addr0",  imem.imem_req_addr, 32'h0);
        chk("a_reqv0",  32'(imem.imem_req_valid), 32'd1);
        step(); #1;
        chk("a_addr4",  imem.imem_req_addr, 32'h4);
        step(); #1;
        chk("a_credit", 32'(imem.imem_req_valid), 32'd0);
        step(); ready = 1'b0; #1;
        chk("a_addr8",  imem.imem_req_addr, 32'h8);
        chk("a_vd1",    32'(ValidD), 32'd1);
        chk("a_instr0", InstrD, TAG);
        chk("a_pcd0",   PCD, 32'h0);
        chk("a_pcp4",   PCPlus4D, 32'h4);
        step(); #1;
        chk("a_instr4", InstrD, TAG | 32'h4);
        chk("a_pcd4",   PCD, 32'h4);
        step(); #1;
        chk("a_drain_v", 32'(ValidD), 32'd0);
        chk("a_drain_i", InstrD, NOP);
        chk("a_drain_pcd", PCD, 32'h4);
        repeat (2) step(); #1;
        chk("a_hold_pcf", PCF, 32'h8);
        chk("a_hold_vd",  32'(ValidD), 32'd0);
        step(); ready = 1'b1; #1;
        chk("a_pcf8",   PCF, 32'h8);
        step(); #1;
        chk("a_pcfc",   PCF, 32'hC);

        // Redirect with two requests in flight (3-cycle memory).
        do_reset(3);
        step(); step();
        PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
        chk("b_redir_reqv", 32'(imem.imem_req_valid), 32'd0);
        step(); PCSrcE = 1'b0; #1;
        chk("b_pcf",    PCF, 32'h100);
        chk("b_wait",   32'(imem.imem_req_valid), 32'd0);
        step(); #1;
        chk("b_addr",   imem.imem_req_addr, 32'h100);
        chk("b_reqv",   32'(imem.imem_req_valid), 32'd1);
        repeat (4) step(); #1;
        chk("b_novalid", 32'(ValidD), 32'd0);
        step(); #1;
        chk("b_vd",     32'(ValidD), 32'd1);
        chk("b_pcd",    PCD, 32'h100);
        chk("b_instr",  InstrD, TAG | 32'h100);
        chk("b_pcp4",   PCPlus4D, 32'h104);
`ifdef FETCH_PERF_EN
        chk("b_perf_drop", perf_dropped, 32'd2);
        chk("b_perf_fet",  perf_fetched, 32'd1);
`endif

        // StallD with a full queue, then FlushD together with StallD.
        do_reset(1);
        repeat (3) step();
        StallD = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) StallD = 1'b0;
            #1;
            chk("c_hold_i", InstrD, TAG);
            chk("c_hold_p", PCD, 32'h0);
            chk("c_reqv",   32'(imem.imem_req_valid), 32'd0);
        end
        step(); #1;
        chk("c_pcd4",   PCD, 32'h4);
        chk("c_instr4", InstrD, TAG | 32'h4);
        step(); FlushD = 1'b1; StallD = 1'b1; #1;
        chk("c_pcd8",   PCD, 32'h8);
        chk("c_instr8", InstrD, TAG | 32'h8);
        step(); #1;
        chk("d_vd",     32'(ValidD), 32'd0);
        chk("d_nop",    InstrD, NOP);
        chk("d_pcd",    PCD, 32'h8);
        step(); FlushD = 1'b0; StallD = 1'b0; #1;
        chk("d_vd2",    32'(ValidD), 32'd0);
        step(); #1;
        chk("d_vd3",    32'(ValidD), 32'd1);
        chk("d_pcdc",   PCD, 32'hC);
        chk("d_instrc", InstrD, TAG | 32'hC);
        step(); #1;
        chk("d_pcd10",  PCD, 32'h10);

        // PC wrap, misaligned target, redirect racing a kept response.
        do_reset(1);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE; #1;
        chk("e_reqv0",  32'(imem.imem_req_valid), 32'd0);
        step(); PCSrcE = 1'b0; #1;
        chk("e_pcf_al", PCF, 32'hFFFF_FFFC);
        chk("e_addr_top", imem.imem_req_addr, 32'hFFFF_FFFC);
        step(); #1;
        chk("e_wrap",   imem.imem_req_addr, 32'h0);
        chk("e_wrap_v", 32'(imem.imem_req_valid), 32'd1);
        PCSrcE = 1'b1; PCTargetE = 32'h202;
        step(); PCSrcE = 1'b0; #1;
        chk("e_addr200", imem.imem_req_addr, 32'h200);
        chk("e_reqv200", 32'(imem.imem_req_valid), 32'd1);
`ifdef FETCH_PERF_EN
        chk("e_perf_drop", perf_dropped, 32'd1);
`endif
        step(); #1;
        chk("e_addr204", imem.imem_req_addr, 32'h204);
        step(); #1;
        chk("e_novalid", 32'(ValidD), 32'd0);
        step(); #1;
        chk("e_vd",     32'(ValidD), 32'd1);
        chk("e_pcd",    PCD, 32'h200);
        chk("e_pcp4",   PCPlus4D, 32'h204);
        chk("e_instr",  InstrD, TAG | 32'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
